vend_change_dispenser: RTL and testbench
========================================

// Module: vend_change_dispenser
// PURPOSE
//   Payout side of the vending coin interface: pays a requested change amount out as
//   Rs.10/Rs.5 coins to a coin hopper, using the same coin encoding as the acceptor
//   (01=Rs.5, 10=Rs.10, 00=none). Sits between the vending controller and the hopper.
//   Keeps per-denomination inventory, greedy-selects coins and reports any shortfall.
//   Flags a hopper fault on handshake timeout.
// PARAMETERS
//   AMT_W       6   width of request amount / remaining, in rupees
//   CNT_W       8   width of each inventory counter
//   INIT_N5     8   Rs.5 coin count loaded at reset
//   INIT_N10    8   Rs.10 coin count loaded at reset
//   ACK_TMO     15  max cycles coin_valid may wait for hopper_ack before FAULT
// PORTS
//   clk         in   1      clock, all logic on rising edge
//   rst_n       in   1      synchronous reset, active low
//   req_valid   in   1      change request valid
//   req_amount  in   AMT_W  change to pay, in rupees
//   req_ready   out  1      dispenser idle, request accepted when valid&ready
//   coin_out    out  2      coin to eject: 01=Rs.5, 10=Rs.10, 00 when not valid
//   coin_valid  out  1      coin_out valid, held until hopper_ack
//   hopper_ack  in   1      hopper took the coin (transfer = valid&ack)
//   refill5     in   1      pulse: one Rs.5 coin added to inventory
//   refill10    in   1      pulse: one Rs.10 coin added to inventory
//   n5          out  CNT_W  Rs.5 inventory
//   n10         out  CNT_W  Rs.10 inventory
//   remaining   out  AMT_W  amount still owed for current request
//   done        out  1      one-cycle pulse, request finished
//   short       out  1      valid with done: remaining != 0 (could not pay in full)
//   fault       out  1      sticky hopper timeout, cleared only by reset
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state IDLE, coin_valid=0, coin_out=00, done=0, short=0,
//     fault=0, remaining=0, n5=INIT_N5, n10=INIT_N10. Mid-payout reset aborts; an
//     in-flight coin is not counted.
//   - States: IDLE, SELECT, ISSUE, DONE, FAULT. req_ready=1 only in IDLE (first cycle
//     after reset included). coin_valid=1 only in ISSUE.
//   - IDLE: on req_valid&req_ready latch remaining<=req_amount -> SELECT.
//   - SELECT: remaining>=10 & n10!=0 -> choose 10; else remaining>=5 & n5!=0 -> choose 5;
//     choice registered into coin_out -> ISSUE. No choice possible -> DONE.
//     Covers remaining=0, non-multiples of 5 (residue 1..4 -> short) and empty inventory.
//   - ISSUE: hold coin_valid and coin_out stable. On hopper_ack: remaining -= coin value,
//     decrement the matching inventory, clear timer -> SELECT.
//     Else timer++; timer reaching ACK_TMO -> FAULT.
//   - DONE: done=1, short=(remaining!=0) for one cycle -> IDLE.
//   - FAULT: coin_valid=0, fault=1, req_ready=0; left only by reset.
//   - Timing: per coin 2 cycles minimum. Request accepted at t -> first coin_valid at t+2.
//     A zero amount gives done at t+2.
//   - Inventory: refill accepted in every state, incl. reset-release cycle. Same-cycle
//     refill and decrement of one denomination nets to no change. Refill at max
//     saturates. Decrement never occurs at 0, because SELECT checks inventory first.
//   - remaining never underflows: subtraction is only taken when remaining >= coin value.
//   - hopper_ack outside ISSUE is ignored.
// STRUCTURE
//   - Shared package vend_pkg: coin codes COIN_NONE/COIN_5/COIN_10, coin values 5/10,
//     dispenser state encoding. The acceptor uses the same coin codes.
//   - Sub-module vend_inv_counter (CNT_W, INIT): saturating up/down counter with
//     simultaneous inc/dec. Instantiated once per denomination.
//   - Top level holds FSM, remaining register and timeout counter.
// TESTING
//   1. Reset, then req 15 with ack always 1 -> coins 10 (t+2), 5 (t+4); done, short=0 at
//      t+6; n10=7, n5=7.
//   2. n10=0 (INIT_N10=0), req 20 -> four Rs.5 coins; done, short=0; n5=4.
//   3. INIT_N5=1, INIT_N10=0, req 15 -> one Rs.5 coin; done with short=1, remaining=10.
//   4. req 7 -> one Rs.5 coin; done with short=1, remaining=2. req 0 -> done at t+2, no coin.
//   5. hopper_ack held 0 -> coin_valid high ACK_TMO cycles, then FAULT: fault=1,
//      req_ready=0; rst_n=0 clears it.
//   6. refill5 in the cycle of a Rs.5 transfer -> n5 unchanged. Refill at 2^CNT_W-1 ->
//      stays. rst_n low mid-ISSUE -> coin_valid=0 on next edge.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin codes, coin values and change dispenser state encoding
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10
    } coin_t;

    localparam int unsigned COIN5_VALUE  = 5;
    localparam int unsigned COIN10_VALUE = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } disp_state_t;

    // Face value in rupees of a coin code; COIN_NONE is worth nothing.
    function automatic int unsigned coin_value(input coin_t coin);
        case (coin)
            COIN_5:  coin_value = COIN5_VALUE;
            COIN_10: coin_value = COIN10_VALUE;
            default: coin_value = 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// rtl/vend_change_dispenser_if.sv - request and hopper handshake bundle of the change dispenser
interface vend_change_dispenser_if
    import vend_pkg::*;
#(
    parameter int AMT_W = 6
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    coin_t            coin_out;
    logic             coin_valid;
    logic             hopper_ack;

    // Vending controller plus hopper side.
    modport master (
        output req_valid,
        output req_amount,
        output hopper_ack,
        input  req_ready,
        input  coin_out,
        input  coin_valid
    );

    // Dispenser side.
    modport slave (
        input  req_valid,
        input  req_amount,
        input  hopper_ack,
        output req_ready,
        output coin_out,
        output coin_valid
    );
endinterface

// File: rtl/vend_inv_counter.sv
// rtl/vend_inv_counter.sv - saturating per-denomination coin inventory counter
module vend_inv_counter #(
    parameter int CNT_W = 8,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Refill and payout in the same cycle cancel; both ends clamp instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= CNT_INIT;
        end else if (inc && !dec && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CNT_ONE;
        end
    end
endmodule

// File: rtl/vend_change_dispenser.sv
// rtl/vend_change_dispenser.sv - greedy Rs.10/Rs.5 change payout FSM with inventory and hopper timeout
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W    = 6,
    parameter int CNT_W    = 8,
    parameter int INIT_N5  = 8,
    parameter int INIT_N10 = 8,
    parameter int ACK_TMO  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vend_change_dispenser_if.slave bus,
    input  logic                  refill5,
    input  logic                  refill10,
    output logic [CNT_W-1:0]      n5,
    output logic [CNT_W-1:0]      n10,
    output logic [AMT_W-1:0]      remaining,
    output logic                  done,
    output logic                  short,
    output logic                  fault
);
    localparam int TMR_W = $clog2(ACK_TMO + 1);
    localparam logic [AMT_W-1:0] VAL5     = AMT_W'(COIN5_VALUE);
    localparam logic [AMT_W-1:0] VAL10    = AMT_W'(COIN10_VALUE);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TMO - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    disp_state_t      state, state_next;
    coin_t            coin_sel, coin_sel_next;
    logic [AMT_W-1:0] remaining_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic             dec5, dec10;

    // Next state, coin choice, owed amount and ack timer; inventory is checked
    // before a coin is chosen so neither counter is ever decremented at zero.
    always_comb begin
        state_next     = state;
        coin_sel_next  = coin_sel;
        remaining_next = remaining;
        timer_next     = timer;
        dec5           = 1'b0;
        dec10          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    remaining_next = bus.req_amount;
                    state_next     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                timer_next = '0;
                if ((remaining >= VAL10) && (n10 != '0)) begin
                    coin_sel_next = COIN_10;
                    state_next    = ST_ISSUE;
                end else if ((remaining >= VAL5) && (n5 != '0)) begin
                    coin_sel_next = COIN_5;
                    state_next    = ST_ISSUE;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (bus.hopper_ack) begin
                    remaining_next = remaining - AMT_W'(coin_value(coin_sel));
                    dec5           = (coin_sel == COIN_5);
                    dec10          = (coin_sel == COIN_10);
                    timer_next     = '0;
                    state_next     = ST_SELECT;
                end else begin
                    timer_next = timer + TMR_ONE;
                    if (timer == TMR_LAST) begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any coin still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            coin_sel  <= COIN_NONE;
            remaining <= '0;
            timer     <= '0;
        end else begin
            state     <= state_next;
            coin_sel  <= coin_sel_next;
            remaining <= remaining_next;
            timer     <= timer_next;
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.coin_valid = (state == ST_ISSUE);
    assign bus.coin_out   = (state == ST_ISSUE) ? coin_sel : COIN_NONE;
    assign done           = (state == ST_DONE);
    assign short          = (state == ST_DONE) && (remaining != '0);
    assign fault          = (state == ST_FAULT);

    vend_inv_counter #(
        .CNT_W (CNT_W),
        .INIT  (INIT_N5)
    ) u_inv5 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (refill5),
        .dec   (dec5),
        .count (n5)
    );

    vend_inv_counter #(
        .CNT_W (CNT_W),
        .INIT  (INIT_N10)
    ) u_inv10 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (refill10),
        .dec   (dec10),
        .count (n10)
    );
endmodule

// File: tb/tb_vend_change_dispenser.sv
// tb/tb_vend_change_dispenser.sv - self-checking bench for vend_change_dispenser
module tb_vend_change_dispenser;
    import vend_pkg::*;

    localparam int AMT_W   = 6;
    localparam int CNT_W   = 8;
    localparam int INIT5   = 8;
    localparam int INIT10  = 8;
    localparam int TMO     = 15;
    localparam int CNT_MAX = 255;

    logic clk;
    logic rst_n;
    logic refill5;
    logic refill10;
    logic [CNT_W-1:0] n5;
    logic [CNT_W-1:0] n10;
    logic [AMT_W-1:0] remaining;
    logic done;
    logic short;
    logic fault;

    vend_change_dispenser_if #(.AMT_W(AMT_W)) bus ();

    vend_change_dispenser #(
        .AMT_W    (AMT_W),
        .CNT_W    (CNT_W),
        .INIT_N5  (INIT5),
        .INIT_N10 (INIT10),
        .ACK_TMO  (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .refill5   (refill5),
        .refill10  (refill10),
        .n5        (n5),
        .n10       (n10),
        .remaining (remaining),
        .done      (done),
        .short     (short),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m5, m10;

    typedef struct {
        int amt;
        int k10;
        int k5;
        int sh;
        int rem;
        int e5;
        int e10;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: pay as many tens as owed and stocked, then as many fives.
    function automatic void greedy(input int amt, input int s5, input int s10,
                                   output int k10, output int k5, output int rem);
        k10 = amt / 10;
        if (k10 > s10) k10 = s10;
        rem = amt - 10 * k10;
        k5 = rem / 5;
        if (k5 > s5) k5 = s5;
        rem = rem - 5 * k5;
    endfunction

    // One request from IDLE, coin-by-coin with cycle-exact timing; maxd = max ack wait.
    task automatic run_req(input int amt, input int k10, input int k5, input int sh,
                           input int rem, input int e5, input int e10, input int maxd);
        int d;
        int exp_coin;
        logic [AMT_W-1:0] a;
        a = AMT_W'(amt);
        chk("req_ready_idle", int'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_amount = a;
        step();
        bus.req_valid  = 1'b0;
        bus.req_amount = AMT_W'($urandom);
        chk("select_no_coin", int'(bus.coin_valid), 0);
        for (int c = 0; c < k10 + k5; c++) begin
            exp_coin = (c < k10) ? 2 : 1;
            bus.hopper_ack = 1'($urandom_range(0, 1));
            step();
            d = $urandom_range(0, maxd);
            bus.hopper_ack = 1'b0;
            for (int j = 0; j < d; j++) begin
                chk("coin_held_valid", int'(bus.coin_valid), 1);
                chk("coin_held_code", int'(bus.coin_out), exp_coin);
                step();
            end
            chk("coin_valid", int'(bus.coin_valid), 1);
            chk("coin_code", int'(bus.coin_out), exp_coin);
            bus.hopper_ack = 1'b1;
            step();
            bus.hopper_ack = 1'b0;
            chk("coin_drop", int'(bus.coin_valid), 0);
            chk("coin_none", int'(bus.coin_out), 0);
        end
        bus.hopper_ack = 1'($urandom_range(0, 1));
        step();
        chk("done", int'(done), 1);
        chk("short", int'(short), sh);
        chk("remaining", int'(remaining), rem);
        chk("n5", int'(n5), e5);
        chk("n10", int'(n10), e10);
        step();
        chk("done_pulse", int'(done), 0);
        chk("back_idle", int'(bus.req_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k10, k5, rem, amt, nref;
        logic r5, r10;

        rst_n = 1'b0;
        refill5 = 1'b0;
        refill10 = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_amount = '0;
        bus.hopper_ack = 1'b0;

        vecs[0] = '{15, 1, 1, 0,  0, 7, 7};
        vecs[1] = '{60, 6, 0, 0,  0, 7, 1};
        vecs[2] = '{10, 1, 0, 0,  0, 7, 0};
        vecs[3] = '{20, 0, 4, 0,  0, 3, 0};
        vecs[4] = '{ 7, 0, 1, 1,  2, 2, 0};
        vecs[5] = '{ 0, 0, 0, 0,  0, 2, 0};
        vecs[6] = '{ 5, 0, 1, 0,  0, 1, 0};
        vecs[7] = '{15, 0, 1, 1, 10, 0, 0};
        vecs[8] = '{15, 0, 0, 1, 15, 0, 0};
        vecs[9] = '{63, 0, 0, 1, 63, 0, 0};

        step();
        step();
        chk("rst_coin_valid", int'(bus.coin_valid), 0);
        chk("rst_coin_out", int'(bus.coin_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_n5", int'(n5), INIT5);
        chk("rst_n10", int'(n10), INIT10);
        rst_n = 1'b1;
        chk("rst_ready", int'(bus.req_ready), 1);

        foreach (vecs[i]) begin
            run_req(vecs[i].amt, vecs[i].k10, vecs[i].k5, vecs[i].sh,
                    vecs[i].rem, vecs[i].e5, vecs[i].e10, 0);
        end
        m5 = 0;
        m10 = 0;

        // Refill landing in the same cycle as a Rs.5 transfer leaves n5 unchanged.
        refill5 = 1'b1;
        step();
        refill5 = 1'b0;
        m5 = 1;
        chk("refill_one", int'(n5), 1);
        bus.req_valid = 1'b1;
        bus.req_amount = AMT_W'(5);
        step();
        bus.req_valid = 1'b0;
        step();
        chk("net_coin", int'(bus.coin_out), 1);
        refill5 = 1'b1;
        bus.hopper_ack = 1'b1;
        step();
        refill5 = 1'b0;
        bus.hopper_ack = 1'b0;
        chk("net_n5", int'(n5), 1);
        chk("net_remaining", int'(remaining), 0);
        step();
        chk("net_done", int'(done), 1);
        chk("net_short", int'(short), 0);
        step();

        // Randomized requests against the greedy reference.
        for (int it = 0; it < 40; it++) begin
            nref = $urandom_range(0, 4);
            for (int j = 0; j < nref; j++) begin
                r5 = 1'($urandom_range(0, 1));
                r10 = 1'($urandom_range(0, 1));
                refill5 = r5;
                refill10 = r10;
                bus.hopper_ack = 1'($urandom_range(0, 1));
                step();
                if (r5 && m5 < CNT_MAX) m5++;
                if (r10 && m10 < CNT_MAX) m10++;
            end
            refill5 = 1'b0;
            refill10 = 1'b0;
            chk("rnd_n5", int'(n5), m5);
            chk("rnd_n10", int'(n10), m10);
            amt = $urandom_range(0, 63);
            greedy(amt, m5, m10, k10, k5, rem);
            run_req(amt, k10, k5, (rem != 0) ? 1 : 0, rem, m5 - k5, m10 - k10, 3);
            m5 = m5 - k5;
            m10 = m10 - k10;
        end

        // Refill saturation at the counter maximum.
        for (int j = 0; j < 300; j++) begin
            refill5 = 1'b1;
            refill10 = 1'b1;
            step();
        end
        refill5 = 1'b0;
        refill10 = 1'b0;
        m5 = CNT_MAX;
        m10 = CNT_MAX;
        chk("sat_n5", int'(n5), m5);
        chk("sat_n10", int'(n10), m10);
        greedy(35, m5, m10, k10, k5, rem);
        run_req(35, k10, k5, 0, rem, m5 - k5, m10 - k10, 2);

        // Hopper never acknowledges: coin held ACK_TMO cycles, then sticky fault.
        bus.hopper_ack = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_amount = AMT_W'(15);
        step();
        bus.req_valid = 1'b0;
        step();
        for (int j = 0; j < TMO; j++) begin
            chk("tmo_valid", int'(bus.coin_valid), 1);
            step();
        end
        chk("fault_set", int'(fault), 1);
        chk("fault_no_coin", int'(bus.coin_valid), 0);
        chk("fault_not_ready", int'(bus.req_ready), 0);
        bus.req_valid = 1'b1;
        bus.hopper_ack = 1'b1;
        step();
        step();
        bus.req_valid = 1'b0;
        bus.hopper_ack = 1'b0;
        chk("fault_sticky", int'(fault), 1);
        chk("fault_still_busy", int'(bus.req_ready), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("fault_cleared", int'(fault), 0);
        chk("fault_rst_ready", int'(bus.req_ready), 1);
        chk("fault_rst_n5", int'(n5), INIT5);
        chk("fault_rst_n10", int'(n10), INIT10);

        // Reset while a coin is on offer drops it without touching inventory.
        bus.req_valid = 1'b1;
        bus.req_amount = AMT_W'(10);
        step();
        bus.req_valid = 1'b0;
        step();
        chk("mid_issue_valid", int'(bus.coin_valid), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", int'(bus.coin_valid), 0);
        chk("mid_rst_n10", int'(n10), INIT10);
        chk("mid_rst_remaining", int'(remaining), 0);

        run_req(15, 1, 1, 0, 0, INIT5 - 1, INIT10 - 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
